// File: rtl/tcm_loader_if.sv
// Byte-stream and TCM write-port bundle for the TCM loader.
// The loader side uses "master" (it masters the TCM write port and sinks the stream);
// the environment side uses "slave".
`timescale 1ns/1ps
interface tcm_loader_if;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        ld_sram_cs;
    logic        ld_sram_we;
    logic [31:0] ld_sram_addr;
    logic [3:0]  ld_sram_ben;
    logic [31:0] ld_sram_wdata;

    modport master (
        input  s_valid, s_data,
        output s_ready,
        output ld_sram_cs, ld_sram_we, ld_sram_addr, ld_sram_ben, ld_sram_wdata
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready,
        input  ld_sram_cs, ld_sram_we, ld_sram_addr, ld_sram_ben, ld_sram_wdata
    );
endinterface

// File: rtl/tcm_loader.sv
// TCM loader: parses a little-endian byte stream (LOAD_ADDR, NWORDS, data words, BOOT),
// writes the data words into ITCM/DTCM and holds the core until the image is complete.
`timescale 1ns/1ps
module tcm_loader #(
    parameter logic [7:0] ITCM_BASE = 8'h80,
    parameter logic [7:0] DTCM_BASE = 8'h90
) (
    input  logic             clk,
    input  logic             cpurst_n,
    input  logic             start,
    tcm_loader_if.master     bus,
    output logic             core_hold,
    output logic [31:0]      boot_addr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR_ADDR, ST_HDR_LEN, ST_DATA, ST_BOOT, ST_DONE, ST_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;          // byte position within the current 32-bit field
    logic [31:0] shift_q, shift_d;      // field assembly, bytes shifted in from the top
    logic [31:0] addr_q, addr_d;        // next TCM word address
    logic [31:0] nwords_q, nwords_d;    // words still to be written
    logic [7:0]  tag_q, tag_d;          // region tag of LOAD_ADDR, used for overflow detection
    logic        cs_q, cs_d;
    logic [31:0] sram_addr_q, sram_addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] boot_q, boot_d;

    logic        s_ready_w;
    logic        accept;
    logic        last_byte;
    logic [31:0] field;
    logic [31:0] addr_inc;
    logic [31:0] nwords_dec;

    // The stream is open in every parsing state; a byte moves on valid & ready.
    assign s_ready_w  = (state_q == ST_HDR_ADDR) || (state_q == ST_HDR_LEN) ||
                        (state_q == ST_DATA)     || (state_q == ST_BOOT);
    assign accept     = bus.s_valid & s_ready_w;
    assign last_byte  = accept && (cnt_q == 2'd3);
    // Little-endian: the first byte ends up in [7:0] after four shifts.
    assign field      = {bus.s_data, shift_q[31:8]};
    assign addr_inc   = addr_q + 32'd4;
    assign nwords_dec = nwords_q - 32'd1;

    // Next-state, field assembly and write-strobe generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        nwords_d    = nwords_q;
        tag_d       = tag_q;
        cs_d        = 1'b0;
        sram_addr_d = sram_addr_q;
        wdata_d     = wdata_q;
        boot_d      = boot_q;

        if (accept) begin
            shift_d = field;
            cnt_d   = cnt_q + 2'd1;
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_HDR_ADDR;
            end
            ST_HDR_ADDR: begin
                if (last_byte) begin
                    if (((field[31:24] == ITCM_BASE) || (field[31:24] == DTCM_BASE)) &&
                        (field[1:0] == 2'b00)) begin
                        state_d = ST_HDR_LEN;
                        addr_d  = field;
                        tag_d   = field[31:24];
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_HDR_LEN: begin
                if (last_byte) begin
                    nwords_d = field;
                    state_d  = (field != 32'd0) ? ST_DATA : ST_BOOT;
                end
            end
            ST_DATA: begin
                if (last_byte) begin
                    // The write is issued even if the increment leaves the region.
                    cs_d        = 1'b1;
                    sram_addr_d = addr_q;
                    wdata_d     = field;
                    addr_d      = addr_inc;
                    nwords_d    = nwords_dec;
                    if (nwords_dec == 32'd0)
                        state_d = ST_BOOT;
                    else if (addr_inc[31:24] != tag_q)
                        state_d = ST_ERR;
                end
            end
            ST_BOOT: begin
                if (last_byte) begin
                    boot_d  = field;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every field starts at byte 0 of a fresh state.
        if (state_d != state_q) cnt_d = 2'd0;
    end

    // State and datapath registers; reset aborts any session and any write in flight.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            shift_q     <= 32'd0;
            addr_q      <= 32'd0;
            nwords_q    <= 32'd0;
            tag_q       <= 8'd0;
            cs_q        <= 1'b0;
            sram_addr_q <= 32'd0;
            wdata_q     <= 32'd0;
            boot_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            nwords_q    <= nwords_d;
            tag_q       <= tag_d;
            cs_q        <= cs_d;
            sram_addr_q <= sram_addr_d;
            wdata_q     <= wdata_d;
            boot_q      <= boot_d;
        end
    end

    assign bus.s_ready       = s_ready_w;
    assign bus.ld_sram_cs    = cs_q;
    assign bus.ld_sram_we    = cs_q;
    assign bus.ld_sram_ben   = {4{cs_q}};
    assign bus.ld_sram_addr  = sram_addr_q;
    assign bus.ld_sram_wdata = wdata_q;

    assign core_hold = (state_q != ST_DONE);
    assign busy      = s_ready_w;
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);
    assign boot_addr = boot_q;

endmodule

// File: tb/tb_tcm_loader.sv
// Bench for tcm_loader: directed byte streams, a stream-level model of the expected
// writes and final status, and a per-cycle checker on the write port.
`timescale 1ns/1ps
module tb_tcm_loader;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        cpurst_n = 1'b0;
    logic        start = 1'b0;
    logic        core_hold, busy, done, err;
    logic [31:0] boot_addr;

    tcm_loader_if bus();

    tcm_loader #(.ITCM_BASE(8'h80), .DTCM_BASE(8'h90)) dut (
        .clk(clk), .cpurst_n(cpurst_n), .start(start), .bus(bus),
        .core_hold(core_hold), .boot_addr(boot_addr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          wr_count = 0;
    int          stalls = 0;
    int          wtimes[$];
    logic [63:0] wlog[$];
    logic [63:0] exp_q[$];
    logic [63:0] exp_w;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] prev_wdata = 32'd0;
    logic [31:0] model_boot = 32'd0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Per-cycle checker: port invariants plus every write against the model queue.
    always @(negedge clk) begin
        if (cpurst_n) begin
            total++;
            if (bus.ld_sram_we !== bus.ld_sram_cs ||
                bus.ld_sram_ben !== (bus.ld_sram_cs ? 4'hf : 4'h0) ||
                bus.s_ready !== busy || core_hold !== ~done || (done && err) ||
                (!bus.ld_sram_cs && (bus.ld_sram_addr !== prev_addr ||
                                     bus.ld_sram_wdata !== prev_wdata))) begin
                bad++;
                $display("FAIL port_invariant: cs=%b we=%b ben=%h rdy=%b busy=%b hold=%b done=%b err=%b addr=%h wdata=%h",
                         bus.ld_sram_cs, bus.ld_sram_we, bus.ld_sram_ben, bus.s_ready, busy,
                         core_hold, done, err, bus.ld_sram_addr, bus.ld_sram_wdata);
            end
            if (bus.ld_sram_cs) begin
                wr_count++;
                wtimes.push_back(cycle);
                wlog.push_back({bus.ld_sram_addr, bus.ld_sram_wdata});
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL write_unexpected: got %h_%h expected no write",
                             bus.ld_sram_addr, bus.ld_sram_wdata);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({bus.ld_sram_addr, bus.ld_sram_wdata} !== exp_w) begin
                        bad++;
                        $display("FAIL write_data: got %h_%h expected %h_%h", bus.ld_sram_addr,
                                 bus.ld_sram_wdata, exp_w[63:32], exp_w[31:0]);
                    end
                end
                $display("write addr=%h data=%h", bus.ld_sram_addr, bus.ld_sram_wdata);
            end
        end
        prev_addr  = bus.ld_sram_addr;
        prev_wdata = bus.ld_sram_wdata;
    end

    function automatic logic [31:0] fld(input bq_t b, input int i);
        return {b[i+3], b[i+2], b[i+1], b[i]};
    endfunction

    // Stream-level model: expected writes, bytes the loader will take, final status.
    task automatic model(input bq_t b, output int used, output bit e_err, output logic [31:0] e_boot);
        logic [31:0] la, n, a;
        e_boot = model_boot;
        e_err  = 1'b1;
        la     = fld(b, 0);
        used   = 4;
        if (!((la[31:24] == 8'h80 || la[31:24] == 8'h90) && la[1:0] == 2'b00)) return;
        n    = fld(b, 4);
        used = 8;
        a    = la;
        for (int k = 0; k < int'(n); k++) begin
            exp_q.push_back({a, fld(b, 8 + 4 * k)});
            used += 4;
            a    += 32'd4;
            if (k < int'(n) - 1 && a[31:24] != la[31:24]) return;
        end
        e_boot = fld(b, used);
        used  += 4;
        e_err  = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        logic rdy;
        bus.s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.s_valid = 1'b1;
        bus.s_data  = v;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); rdy = bus.s_ready;
            @(posedge clk); #1;
            if (rdy) return;
            stalls++;
        end
        total++; bad++;
        $display("FAIL byte_accept: got no s_ready in 50 cycles required s_ready=1");
    endtask

    task automatic run_session(input string name, input bq_t b, input bit rnd);
        int used;
        bit e_err;
        logic [31:0] e_boot;
        int w0;
        w0 = wr_count;
        wtimes.delete(); wlog.delete(); stalls = 0;
        model(b, used, e_err, e_boot);
        do_start();
        for (int i = 0; i < used; i++) send_byte(b[i], rnd ? int'($urandom_range(0, 2)) : 0);
        bus.s_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done || err) break;
        end
        repeat (2) @(negedge clk);
        chk({name, "_done"}, 64'(done), 64'(!e_err));
        chk({name, "_err"}, 64'(err), 64'(e_err));
        chk({name, "_boot"}, 64'(boot_addr), 64'(e_boot));
        chk({name, "_hold"}, 64'(core_hold), 64'(e_err));
        chk({name, "_ready"}, 64'(bus.s_ready), 64'd0);
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        if (!e_err) model_boot = e_boot;
        exp_q.delete();
        $display("session %s: writes=%0d done=%0b err=%0b boot=%h", name, wr_count - w0, done, err, boot_addr);
    endtask

    bq_t nom, zlen, badt, bada, ovf, edge1, thr, hdr;
    int  w0;

    initial begin
        nom   = '{8'h00,8'h00,8'h00,8'h80, 8'h02,8'h00,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44,
                  8'h55,8'h66,8'h77,8'h88, 8'h00,8'h01,8'h00,8'h80};
        zlen  = '{8'h00,8'h00,8'h00,8'h90, 8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h80};
        badt  = '{8'h00,8'h00,8'h00,8'hA0};
        bada  = '{8'h02,8'h00,8'h00,8'h80};
        ovf   = '{8'hFC,8'hFF,8'hFF,8'h80, 8'h02,8'h00,8'h00,8'h00, 8'hA1,8'hA2,8'hA3,8'hA4,
                  8'hB1,8'hB2,8'hB3,8'hB4, 8'h00,8'h00,8'h00,8'h80};
        edge1 = '{8'hFC,8'hFF,8'hFF,8'h80, 8'h01,8'h00,8'h00,8'h00, 8'hDE,8'hAD,8'hBE,8'hEF,
                  8'h04,8'h03,8'h02,8'h01};
        thr   = '{8'h00,8'h00,8'h00,8'h90, 8'h03,8'h00,8'h00,8'h00, 8'h01,8'h02,8'h03,8'h04,
                  8'h05,8'h06,8'h07,8'h08, 8'h09,8'h0A,8'h0B,8'h0C, 8'h40,8'h00,8'h00,8'h90};
        hdr   = '{8'h00,8'h00,8'h00,8'h80, 8'h02,8'h00,8'h00,8'h00, 8'h10,8'h20,8'h30,8'h40,
                  8'h50,8'h60};

        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_cs", 64'(bus.ld_sram_cs), 64'd0);
        chk("rst_we", 64'(bus.ld_sram_we), 64'd0);
        chk("rst_addr", 64'(bus.ld_sram_addr), 64'd0);
        chk("rst_wdata", 64'(bus.ld_sram_wdata), 64'd0);
        chk("rst_ben", 64'(bus.ld_sram_ben), 64'd0);
        chk("rst_hold", 64'(core_hold), 64'd1);
        chk("rst_boot", 64'(boot_addr), 64'd0);
        chk("rst_status", 64'({busy, done, err}), 64'd0);
        @(posedge clk); #1 cpurst_n = 1'b1;

        // Bytes offered without start are ignored; the block stays idle.
        bus.s_valid = 1'b1; bus.s_data = 8'h5A;
        repeat (6) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_hold", 64'(core_hold), 64'd1);
        chk("idle_writes", 64'(wr_count), 64'd0);
        @(posedge clk); #1 bus.s_valid = 1'b0;

        run_session("nominal", nom, 1'b0);
        chk("nominal_w0", wlog[0], 64'h80000000_44332211);
        chk("nominal_w1", wlog[1], 64'h80000004_88776655);
        chk("nominal_boot_lit", 64'(boot_addr), 64'h80000100);
        chk("nominal_stalls", 64'(stalls), 64'd0);

        w0 = wr_count;
        run_session("nominal_bp", nom, 1'b1);
        chk("nominal_bp_writes", 64'(wr_count - w0), 64'd2);

        w0 = wr_count;
        run_session("zero_len", zlen, 1'b0);
        chk("zero_len_writes", 64'(wr_count - w0), 64'd0);
        chk("zero_len_boot_lit", 64'(boot_addr), 64'h80000000);

        run_session("bad_tag", badt, 1'b0);
        chk("bad_tag_err_lit", 64'(err), 64'd1);
        run_session("bad_align", bada, 1'b1);
        chk("bad_align_err_lit", 64'(err), 64'd1);

        w0 = wr_count;
        run_session("overflow", ovf, 1'b0);
        chk("overflow_writes", 64'(wr_count - w0), 64'd1);
        chk("overflow_w0", wlog[0], 64'h80FFFFFC_A4A3A2A1);

        run_session("last_word_edge", edge1, 1'b1);
        chk("last_word_boot_lit", 64'(boot_addr), 64'h01020304);

        run_session("throughput", thr, 1'b0);
        chk("thr_gap01", 64'(wtimes[1] - wtimes[0]), 64'd4);
        chk("thr_gap12", 64'(wtimes[2] - wtimes[1]), 64'd4);
        chk("thr_stalls", 64'(stalls), 64'd0);

        // Restart from DONE, then reset after 6 data bytes.
        w0 = wr_count;
        do_start();
        chk("restart_hold", 64'(core_hold), 64'd1);
        exp_q.push_back(64'h80000000_40302010);
        for (int i = 0; i < 14; i++) send_byte(hdr[i], 0);
        cpurst_n = 1'b0;
        #1;
        chk("midrst_status", 64'({busy, done, err, bus.s_ready}), 64'd0);
        chk("midrst_hold", 64'(core_hold), 64'd1);
        chk("midrst_boot", 64'(boot_addr), 64'd0);
        bus.s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 cpurst_n = 1'b1;
        model_boot = 32'd0;
        chk("midrst_writes", 64'(wr_count - w0), 64'd1);
        chk("midrst_pending", 64'(exp_q.size()), 64'd0);
        $display("session reset_mid_data: writes=%0d", wr_count - w0);

        // Reset landing in the write pulse cancels it.
        w0 = wr_count;
        do_start();
        for (int i = 0; i < 12; i++) send_byte(hdr[i], 0);
        bus.s_valid = 1'b0;
        chk("pulse_before_rst", 64'(bus.ld_sram_cs), 64'd1);
        cpurst_n = 1'b0;
        #1;
        chk("pulse_killed", 64'({bus.ld_sram_cs, bus.ld_sram_we, bus.ld_sram_ben}), 64'd0);
        chk("pulse_addr_cleared", 64'(bus.ld_sram_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1 cpurst_n = 1'b1;
        chk("pulse_writes", 64'(wr_count - w0), 64'd0);
        $display("session reset_in_pulse: writes=%0d", wr_count - w0);

        run_session("after_reset", nom, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
